parada_rampa_parcial: RTL and testbench

Soft-stop controller, the deceleration counterpart of the start ramp (`arranque_rampa_parcial`).
- On a stop request it captures the motor's current speed level (one-hot 30/50/100 %) from the start ramp.
- It steps the level down 100 → 50 → 30 → 0, holding each step for a tick-counted dwell time.
- It signals completion with a `done` pulse.
- It sits beside the start ramp in `tt_um_fsm_top` and runs on the system clock with a prescaler tick enable, never a derived clock.

---
 rtl/parada_rampa_parcial_pkg.sv | 27 ++
 rtl/parada_rampa_parcial_dwell_timer.sv | 29 ++
 rtl/parada_rampa_parcial.sv | 129 ++++++++++++
 tb/tb_parada_rampa_parcial.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/parada_rampa_parcial_pkg.sv
// Shared types for the soft-stop ramp: FSM states and one-hot level codes.
package parada_pkg;

   typedef enum logic [2:0] {
      IDLE,
      S100,
      S50,
      S30,
      DONE
   } state_t;

   localparam logic [2:0] LVL_100 = 3'b100;
   localparam logic [2:0] LVL_50  = 3'b010;
   localparam logic [2:0] LVL_30  = 3'b001;
   localparam logic [2:0] LVL_0   = 3'b000;

   // Level pattern ordered {out_100, out_50, out_30} driven in each state.
   function automatic logic [2:0] state_level(input state_t s);
      case (s)
         S100:    state_level = LVL_100;
         S50:     state_level = LVL_50;
         S30:     state_level = LVL_30;
         default: state_level = LVL_0;
      endcase
   endfunction

endpackage

// File: rtl/parada_rampa_parcial_dwell_timer.sv
// Tick-counted dwell timer; expire flags the tick that completes 'limit' ticks.
module dwell_timer #(
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clr,
   input  logic           tick,
   input  logic [CNT_W:0] limit,
   output logic           expire
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W:0]   LIM_ONE = 1;

   logic [CNT_W-1:0] count_q;

   // limit is one bit wider so a dwell of exactly 2**CNT_W stays representable.
   assign expire = tick & ({1'b0, count_q} == (limit - LIM_ONE));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_q <= '0;
      end else if (tick) begin
         count_q <= count_q + CNT_ONE;
      end
   end

endmodule

// File: rtl/parada_rampa_parcial.sv
// Soft-stop controller: steps the captured level down 100 -> 50 -> 30 -> 0.
// Build option PARADA_ERR_EN: reject multi-hot level_in and raise sticky err.
module parada_rampa_parcial
   import parada_pkg::*;
#(
   parameter int DWELL_FAST = 2,
   parameter int DWELL_SLOW = 5,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       stop_req,
   input  logic       Rapido,
   input  logic       Lento,
   input  logic [2:0] level_in,
   output logic       out_30,
   output logic       out_50,
   output logic       out_100,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [CNT_W:0] LIM_FAST = (CNT_W+1)'((DWELL_FAST == 0) ? 1 : DWELL_FAST);
   localparam logic [CNT_W:0] LIM_SLOW = (CNT_W+1)'((DWELL_SLOW == 0) ? 1 : DWELL_SLOW);

   state_t     state_q, state_d;
   logic       fast_q, fast_d;
   logic       stop_q;
   logic       stop_rise;
   logic [2:0] lvl_q;
   logic       busy_q;
   logic       done_q;
   logic       clr;
   logic       expire;

   assign stop_rise = stop_req & ~stop_q;

   // Lento only matters when Rapido is low, where slow is the default anyway.
   logic unused_lento;
   assign unused_lento = Lento;

   // Idle keeps the counter parked so a tick in the capture cycle is ignored.
   assign clr = (state_d != state_q) || (state_q == IDLE);

   dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .tick   (tick),
      .limit  (fast_q ? LIM_FAST : LIM_SLOW),
      .expire (expire)
   );

`ifdef PARADA_ERR_EN
   logic err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      fast_d  = fast_q;
`ifdef PARADA_ERR_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (stop_rise) begin
               fast_d = Rapido;
`ifdef PARADA_ERR_EN
               case (level_in)
                  LVL_100: state_d = S100;
                  LVL_50:  state_d = S50;
                  LVL_30:  state_d = S30;
                  LVL_0:   state_d = DONE;
                  default: err_d   = 1'b1;
               endcase
`else
               if (level_in[2])      state_d = S100;
               else if (level_in[1]) state_d = S50;
               else if (level_in[0]) state_d = S30;
               else                  state_d = DONE;
`endif
            end
         end
         S100:    if (expire) state_d = S50;
         S50:     if (expire) state_d = S30;
         S30:     if (expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         fast_q  <= 1'b0;
         stop_q  <= 1'b0;
         lvl_q   <= LVL_0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PARADA_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fast_q  <= fast_d;
         stop_q  <= stop_req;
         lvl_q   <= state_level(state_d);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
`ifdef PARADA_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign out_100 = lvl_q[2];
   assign out_50  = lvl_q[1];
   assign out_30  = lvl_q[0];
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_parada_rampa_parcial.sv
// Directed bench for parada_rampa_parcial with default dwell parameters (fast 2, slow 5).
module tb_parada_rampa_parcial;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       stop_req;
   logic       Rapido;
   logic       Lento;
   logic [2:0] level_in;
   logic       out_30, out_50, out_100, busy, done, err;

   int tests = 0;
   int fails = 0;
   logic exp_err = 1'b0;

   parada_rampa_parcial dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .stop_req (stop_req),
      .Rapido   (Rapido),
      .Lento    (Lento),
      .level_in (level_in),
      .out_30   (out_30),
      .out_50   (out_50),
      .out_100  (out_100),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] lvl();
      return {out_100, out_50, out_30};
   endfunction

   // Expected level after n ticks from start stage s (0=100, 1=50, 2=30) with dwell d.
   function automatic logic [2:0] exp_lvl(input int s, input int n, input int d);
      int st;
      st = s + n / d;
      case (st)
         0:       return 3'b100;
         1:       return 3'b010;
         2:       return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic capture(input logic [2:0] l, input logic rap, input logic len, input logic tk);
      stop_req = 1'b0;
      tick     = 1'b0;
      clk1();
      level_in = l;
      Rapido   = rap;
      Lento    = len;
      stop_req = 1'b1;
      tick     = tk;
      clk1();
      tick     = 1'b0;
      stop_req = 1'b0;
      $display("[TB] capture level_in=%b Rapido=%b Lento=%b -> lvl=%b busy=%b done=%b err=%b",
               l, rap, len, lvl(), busy, done, err);
   endtask

   // Drives one tick every p cycles from the entry cycle and checks every cycle.
   task automatic ramp(input int s, input int d, input int p, input bit retrig);
      int total;
      total = (3 - s) * d;
      for (int n = 1; n <= total; n++) begin
         tick = 1'b1;
         clk1();
         tick = 1'b0;
         chk("lvl_tick", {5'd0, lvl()}, {5'd0, exp_lvl(s, n, d)});
         chk("done_tick", {7'd0, done}, {7'd0, (n == total)});
         chk("busy_tick", {7'd0, busy}, 8'd1);
         if (n < total) begin
            for (int j = 1; j < p; j++) begin
               if (retrig && n == 1) stop_req = (j >= 2);
               clk1();
               chk("lvl_hold", {5'd0, lvl()}, {5'd0, exp_lvl(s, n, d)});
               chk("done_hold", {7'd0, done}, 8'd0);
            end
         end
      end
      clk1();
      chk("end_state", {5'd0, lvl(), busy, done}, 8'd0);
      $display("[TB] ramp from stage %0d dwell %0d period %0d retrig %0d finished", s, d, p, retrig);
   endtask

   initial begin
      reset    = 1'b1;
      tick     = 1'b0;
      stop_req = 1'b0;
      Rapido   = 1'b0;
      Lento    = 1'b0;
      level_in = 3'b000;
      clk1();
      clk1();
      chk("reset_outputs", {2'd0, lvl(), busy, done, err}, 8'd0);
      reset = 1'b0;
      clk1();
      chk("idle_outputs", {2'd0, lvl(), busy, done, err}, 8'd0);

      // Full slow ramp from 100 with a tick every 4 cycles.
      capture(3'b100, 1'b0, 1'b1, 1'b0);
      chk("slow_entry", {5'd0, lvl()}, 8'b100);
      chk("slow_entry_busy", {6'd0, busy, done}, 8'b10);
      ramp(0, 5, 4, 1'b0);

      // Fast ramp from 50; the tick in the capture cycle must not count.
      capture(3'b010, 1'b1, 1'b1, 1'b1);
      chk("fast_entry", {5'd0, lvl()}, 8'b010);
      ramp(1, 2, 4, 1'b0);

      // Zero level goes straight to a single done pulse.
      capture(3'b000, 1'b0, 1'b0, 1'b0);
      chk("zero_done", {5'd0, lvl()}, 8'd0);
      chk("zero_pulse", {6'd0, busy, done}, 8'b11);
      clk1();
      chk("zero_after", {6'd0, busy, done}, 8'd0);

      // Multi-hot level.
      capture(3'b110, 1'b1, 1'b0, 1'b0);
`ifdef PARADA_ERR_EN
      exp_err = 1'b1;
      chk("illegal_err", {7'd0, err}, 8'd1);
      chk("illegal_idle", {6'd0, lvl(), busy}, 8'd0);
`else
      chk("illegal_err", {7'd0, err}, 8'd0);
      chk("illegal_prio", {5'd0, lvl()}, 8'b100);
      ramp(0, 2, 3, 1'b0);
`endif

      // A legal capture still works afterwards and err stays as it was.
      capture(3'b001, 1'b1, 1'b0, 1'b0);
      chk("after_err_entry", {5'd0, lvl()}, 8'b001);
      ramp(2, 2, 2, 1'b0);
      chk("err_sticky", {7'd0, err}, {7'd0, exp_err});

      // Reset during S50.
      capture(3'b010, 1'b0, 1'b1, 1'b0);
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1();
      chk("pre_reset_s50", {5'd0, lvl()}, 8'b010);
      reset = 1'b1;
      clk1();
      exp_err = 1'b0;
      chk("midreset_outputs", {2'd0, lvl(), busy, done, err}, 8'd0);
      reset = 1'b0;
      clk1();
      chk("post_reset_nodone", {2'd0, lvl(), busy, done, err}, 8'd0);
      capture(3'b001, 1'b1, 1'b0, 1'b0);
      chk("post_reset_s30", {5'd0, lvl()}, 8'b001);
      ramp(2, 2, 3, 1'b0);

      // Re-trigger during S100 is ignored.
      capture(3'b100, 1'b1, 1'b0, 1'b0);
      chk("retrig_entry", {5'd0, lvl()}, 8'b100);
      ramp(0, 2, 4, 1'b1);
      clk1();
      chk("retrig_no_second", {5'd0, lvl(), busy, done}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
